// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage program-counter unit.
package pc_pkg;

  // Resolved next-pc source, one per winning control action.
  localparam logic [2:0] SEL_HOLD   = 3'd0;
  localparam logic [2:0] SEL_RET    = 3'd1;
  localparam logic [2:0] SEL_CALL   = 3'd2;
  localparam logic [2:0] SEL_JUMP   = 3'd3;
  localparam logic [2:0] SEL_BRANCH = 3'd4;
  localparam logic [2:0] SEL_INC    = 3'd5;

  // Sign-extend the low off_w bits of off to 32 bits; callers truncate to ADDR_W.
  function automatic logic [31:0] sext_off(input logic [31:0] off, input int off_w);
    logic [31:0] mask;
    logic        sign;
    mask = 32'hFFFF_FFFF << off_w;
    sign = |(off & (32'h1 << (off_w - 1)));
    return sign ? (off | mask) : (off & ~mask);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: write pointer plus occupancy count.
// Overflow overwrites the oldest entry; underflow leaves the stack untouched.
// Both raise a sticky error that only reset clears.
module pc_ras
  #(parameter int ADDR_W    = 8,
    parameter int RAS_DEPTH = 4)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              push_i,
   input  logic              pop_i,
   input  logic [ADDR_W-1:0] push_data_i,
   output logic [ADDR_W-1:0] pop_data_o,
   output logic              empty_o,
   output logic              full_o,
   output logic              err_o);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [RAS_DEPTH-1:0][ADDR_W-1:0] mem_q;
  logic [PW-1:0]                    wp_q, wp_d;
  logic [CW-1:0]                    cnt_q, cnt_d;
  logic                             err_q, err_d;

  assign empty_o    = (cnt_q == '0);
  assign full_o     = (cnt_q == CW'(RAS_DEPTH));
  assign err_o      = err_q;
  assign pop_data_o = mem_q[wp_q - PW'(1)];

  // Pointer/count/error next state; pop wins if both are ever asserted.
  always_comb begin
    wp_d  = wp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (pop_i) begin
      if (empty_o) err_d = 1'b1;
      else begin
        wp_d  = wp_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end else if (push_i) begin
      wp_d = wp_q + PW'(1);
      if (full_o) err_d = 1'b1;
      else        cnt_d = cnt_q + CW'(1);
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      wp_q  <= wp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push_i && !pop_i) mem_q[wp_q] <= push_data_i;
  end

endmodule

// File: rtl/pc_unit.sv
// Program-counter unit: strobe priority resolver, next-pc mux, pc register,
// and a return-address stack for call/ret.
module pc_unit
  import pc_pkg::*;
  #(parameter int                ADDR_W    = 8,
    parameter int                OFF_W     = 8,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0)
  (input  logic              clk,
   input  logic              rst_n,
   input  logic              stall_i,
   input  logic              branch_taken_i,
   input  logic [OFF_W-1:0]  offset_i,
   input  logic              jump_i,
   input  logic              call_i,
   input  logic              ret_i,
   input  logic [ADDR_W-1:0] target_i,
   output logic [ADDR_W-1:0] pc_o,
   output logic [ADDR_W-1:0] pc_plus1_o,
   output logic              ras_empty_o,
   output logic              ras_full_o,
   output logic              ras_err_o);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] pop_data;
  logic [31:0]       off_ext;
  logic [2:0]        sel;
  logic              push, pop;

  assign pc_o       = pc_q;
  assign pc_plus1_o = pc_q + ADDR_W'(1);
  assign off_ext    = sext_off(32'(offset_i), OFF_W);

  // Priority: stall > ret > call > jump > branch > increment.
  always_comb begin
    sel = SEL_INC;
    if      (stall_i)        sel = SEL_HOLD;
    else if (ret_i)          sel = SEL_RET;
    else if (call_i)         sel = SEL_CALL;
    else if (jump_i)         sel = SEL_JUMP;
    else if (branch_taken_i) sel = SEL_BRANCH;
  end

  // Only the winning action touches the stack; ret on empty still pops to flag underflow.
  assign push = (sel == SEL_CALL);
  assign pop  = (sel == SEL_RET);

  // Next-pc mux; underflowing ret falls through to the sequential address.
  always_comb begin
    pc_d = pc_plus1_o;
    case (sel)
      SEL_HOLD:   pc_d = pc_q;
      SEL_RET:    pc_d = ras_empty_o ? pc_plus1_o : pop_data;
      SEL_CALL:   pc_d = target_i;
      SEL_JUMP:   pc_d = target_i;
      SEL_BRANCH: pc_d = pc_q + off_ext[ADDR_W-1:0];
      default:    pc_d = pc_plus1_o;
    endcase
  end

  // pc register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_VEC;
    else        pc_q <= pc_d;
  end

  pc_ras #(.ADDR_W(ADDR_W), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (pc_plus1_o),
    .pop_data_o  (pop_data),
    .empty_o     (ras_empty_o),
    .full_o      (ras_full_o),
    .err_o       (ras_err_o));

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_pc_unit;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       stall = 0, br = 0, jp = 0, cl = 0, rt = 0;
  logic [7:0] off = 0, tgt = 0;
  logic [7:0] pc, pcp1;
  logic       empty, full, err;

  int checks = 0;
  int errors = 0;

  pc_unit #(.ADDR_W(8), .OFF_W(8), .RAS_DEPTH(4), .RESET_VEC(8'h10)) dut (
    .clk(clk), .rst_n(rst_n), .stall_i(stall), .branch_taken_i(br),
    .offset_i(off), .jump_i(jp), .call_i(cl), .ret_i(rt), .target_i(tgt),
    .pc_o(pc), .pc_plus1_o(pcp1), .ras_empty_o(empty), .ras_full_o(full),
    .ras_err_o(err));

  always #5 clk = ~clk;

  // Reference model: pc as an integer, stack as a bounded queue (newest at back).
  logic [7:0] m_pc;
  logic [7:0] m_stk[$];
  logic       m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc  = 8'h10;
      m_stk = {};
      m_err = 0;
    end else if (stall) begin
      // nothing changes
    end else if (rt) begin
      if (m_stk.size() == 0) begin m_err = 1; m_pc = m_pc + 8'd1; end
      else m_pc = m_stk.pop_back();
    end else if (cl) begin
      if (m_stk.size() == 4) begin void'(m_stk.pop_front()); m_err = 1; end
      m_stk.push_back(m_pc + 8'd1);
      m_pc = tgt;
    end else if (jp) m_pc = tgt;
    else if (br)     m_pc = m_pc + off;
    else             m_pc = m_pc + 8'd1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_pc", pc, m_pc);
      chk("model_pcp1", pcp1, 8'(m_pc + 8'd1));
      chk("model_empty", empty, m_stk.size() == 0);
      chk("model_full", full, m_stk.size() == 4);
      chk("model_err", err, m_err);
    end
  end

  // Drive one cycle of strobes (from a negedge), then clear them.
  task automatic op(input logic s, input logic b, input logic [7:0] o,
                    input logic j, input logic c, input logic r, input logic [7:0] t);
    stall = s; br = b; off = o; jp = j; cl = c; rt = r; tgt = t;
    @(negedge clk);
    stall = 0; br = 0; jp = 0; cl = 0; rt = 0;
  endtask

  task automatic idle();        op(0,0,0,0,0,0,0); endtask
  task automatic jump(input logic [7:0] t); op(0,0,0,1,0,0,t); endtask
  task automatic call(input logic [7:0] t); op(0,0,0,0,1,0,t); endtask
  task automatic ret();         op(0,0,0,0,0,1,0); endtask

  initial begin
    // 1. reset, increment, stall, wrap
    #12;
    chk("rst_pc", pc, 8'h10);
    chk("rst_pcp1", pcp1, 8'h11);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_err", err, 0);
    @(negedge clk); rst_n = 1;
    chk("rel_pc", pc, 8'h10);
    idle(); chk("inc1", pc, 8'h11);
    idle(); chk("inc2", pc, 8'h12);
    idle(); chk("inc3", pc, 8'h13);
    op(1,0,0,0,0,0,0); op(1,0,0,0,0,0,0); chk("stall", pc, 8'h13);
    jump(8'hFF); chk("jump_ff", pc, 8'hFF); chk("pcp1_wrap", pcp1, 8'h00);
    idle(); chk("wrap", pc, 8'h00);

    // 2. branches
    jump(8'h20);
    op(0,1,8'hFC,0,0,0,0); chk("br_neg", pc, 8'h1C);
    op(0,1,8'h7F,0,0,0,0); chk("br_pos", pc, 8'h9B);

    // 3. call/ret pair
    jump(8'h30);
    call(8'h80); chk("call_pc", pc, 8'h80); chk("call_empty", empty, 0);
    ret();       chk("ret_pc", pc, 8'h31); chk("ret_empty", empty, 1); chk("ret_err", err, 0);

    // 4. overflow and underflow
    jump(8'h40);
    call(8'h50); call(8'h60); call(8'h70);
    chk("full3", full, 0);
    call(8'h90); chk("full4", full, 1); chk("err4", err, 0);
    call(8'hA0); chk("err5", err, 1); chk("full5", full, 1); chk("pc5", pc, 8'hA0);
    ret(); chk("pop1", pc, 8'h91);
    ret(); chk("pop2", pc, 8'h71);
    ret(); chk("pop3", pc, 8'h61);
    ret(); chk("pop4", pc, 8'h51); chk("pop4_empty", empty, 1);
    ret(); chk("under_pc", pc, 8'h52); chk("under_err", err, 1);

    // 5. simultaneous strobes
    jump(8'h54);
    call(8'h60);
    op(1,0,0,0,1,0,8'h99); chk("stall_call_pc", pc, 8'h60); chk("stall_call_empty", empty, 0);
    op(0,0,0,1,1,1,8'h77); chk("ret_wins_pc", pc, 8'h55); chk("ret_wins_empty", empty, 1);
    op(0,1,8'h05,1,0,0,8'h33); chk("jump_over_br", pc, 8'h33);

    // 6. asynchronous reset mid-cycle
    call(8'h10); call(8'h20);
    chk("pre_rst_pc", pc, 8'h20); chk("pre_rst_err", err, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_pc", pc, 8'h10);
    chk("arst_empty", empty, 1);
    chk("arst_full", full, 0);
    chk("arst_err", err, 0);
    @(negedge clk); rst_n = 1;
    idle(); chk("post_rst_inc", pc, 8'h11);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter unit for the CPU fetch stage. It holds the current instruction address and selects the next one each cycle.
- Next-address sources: sequential increment, PC-relative branch, absolute jump, call and return.
- Adds stall, a hardware return-address stack (RAS) with full/empty/error status, and a configurable reset vector.
- Sits between the control unit (control strobes) and instruction memory (address).

Parameters:
- ADDR_W, 8, width of pc, target and return addresses
- OFF_W, 8, width of the signed branch offset (OFF_W <= ADDR_W)
- RAS_DEPTH, 4, number of return-address stack entries (power of two, >= 2)
- RESET_VEC, 0, value loaded into pc on reset (ADDR_W bits)

Ports:
- clk  in  1  clock, rising-edge active
- rst_n  in  1  reset, asynchronous, active-low
- stall  in  1  hold pc and stack unchanged this cycle
- branch_taken  in  1  pc <= pc + sext(offset)
- offset  in  OFF_W  signed two's-complement branch displacement
- jump  in  1  pc <= target
- call  in  1  push pc+1, pc <= target
- ret  in  1  pop stack, pc <= popped address
- target  in  ADDR_W  absolute jump/call destination
- pc  out  ADDR_W  current instruction address (registered)
- pc_plus1  out  ADDR_W  pc + 1 mod 2^ADDR_W (combinational from pc)
- ras_empty  out  1  stack holds 0 entries
- ras_full  out  1  stack holds RAS_DEPTH entries
- ras_err  out  1  sticky: overflow or underflow has occurred

Behaviour:
- Reset (rst_n low, asynchronous):
  - pc = RESET_VEC; pc_plus1 = RESET_VEC+1.
  - Stack count = 0, so ras_empty=1 and ras_full=0.
  - ras_err = 0. Stack entry contents are don't-care.
- All state updates occur on the rising edge of clk. Control effects are visible on pc one cycle after the strobe (latency 1).
- Priority when several strobes are high in the same cycle, highest first: stall > ret > call > jump > branch_taken > increment. Only the winning action takes effect; the lower-priority strobes are ignored entirely, including any stack effect.
- Increment (no strobe high): pc <= pc + 1.
- Branch: pc <= pc + sign-extend(offset) to ADDR_W.
- Jump: pc <= target.
- Arithmetic rule: all additions are modulo 2^ADDR_W and wrap silently. 0xFF + 1 = 0x00; 0x02 + (-4) = 0xFE.
- Call: push pc_plus1, pc <= target.
  - If not full: count += 1.
  - If full (overflow): the stack is circular. The oldest entry is overwritten, count stays RAS_DEPTH, and ras_err <= 1. The jump to target still happens.
- Ret: pop the most recent entry.
  - If not empty: pc <= popped value, count -= 1.
  - If empty (underflow): pc <= pc + 1, stack unchanged, ras_err <= 1.
- Stall: pc, stack pointer, count and ras_err are all held.
- ras_err stays set until reset; nothing else clears it.
- Stack implementation: a write pointer and a count.
  - Push writes at wp, then wp <= wp+1 mod RAS_DEPTH.
  - Pop reads entry wp-1, then wp <= wp-1.
  - The popped value is read in the same cycle as ret is sampled; there are no bubbles.
- Reset asserted mid-operation aborts any action immediately. Release is synchronous to the design: the first edge after rst_n rises performs the normal increment, RESET_VEC -> RESET_VEC+1, unless a strobe is high.

Decomposition:
- Shared package pc_pkg holds:
  - localparam encodings for the resolved next-pc select: SEL_HOLD, SEL_RET, SEL_CALL, SEL_JUMP, SEL_BRANCH, SEL_INC
  - function sext_off for sign-extending the branch offset
- Sub-module pc_ras:
  - circular return-address stack, parametrised by ADDR_W and RAS_DEPTH
  - ports: push, pop, push_data, pop_data, empty, full, err
- pc_unit itself contains the priority resolver, the next-pc mux and the pc register.

Test Plan (ADDR_W=8, OFF_W=8, RAS_DEPTH=4, RESET_VEC=0x10):
1. Reset then 3 idle cycles -> pc sequence 0x10, 0x11, 0x12, 0x13. Hold stall=1 for 2 cycles -> pc stays 0x13. Force pc=0xFF via jump, then idle -> pc = 0x00 (wrap).
2. pc=0x20 with branch_taken=1, offset=0xFC (-4) -> pc=0x1C. pc=0x1C with offset=0x7F -> pc=0x9B.
3. pc=0x30 with call=1, target=0x80 -> pc=0x80, ras_empty=0. Next cycle ret=1 -> pc=0x31, ras_empty=1, ras_err=0.
4. Issue 5 nested calls from pc 0x40, 0x50, 0x60, 0x70, 0x90 -> ras_full=1 after the 4th call, ras_err=1 after the 5th. Four rets return 0x91, 0x71, 0x61, 0x51 (0x41 was overwritten). A 5th ret -> pc+1, ras_err stays 1.
5. Simultaneous events:
   - stall=1 with call=1 -> no change to pc or stack.
   - ret=1, call=1, jump=1 all high with stack holding 0x55 -> pc=0x55, count decreases by 1, no push.
   - jump=1 with branch_taken=1 -> pc=target.
6. Assert rst_n=0 asynchronously mid-cycle while the stack holds 2 entries and ras_err=1 -> pc=0x10 immediately (before the next edge), ras_empty=1, ras_err=0.
